// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the MIPS pipeline. This module owns the program
// counter and drives the instruction-memory address. It registers each
// fetched word, together with its PC+4, into the IF/ID pipeline register.
//
// Per-edge priority, highest first: reset > branch redirect > stall > fetch.
//
// Parameters
//   PC_RESET        PC loaded on reset (word aligned)
//   NOP_WORD        bubble word placed in IF/ID on reset or redirect
//
// Ports
//   clk_i           rising-edge clock
//   reset_n_i       synchronous, active-low reset
//   stall_i         hold PC, IF/ID and fetch counter this cycle
//   branch_taken_i  redirect fetch to branch_target_i and squash IF/ID
//   branch_target_i redirect address, bits [1:0] forced to zero
//   imem_data_i     instruction word at imem_addr_o (combinational memory)
//   imem_addr_o     current PC
//   instr_o         IF/ID instruction register
//   pc_plus4_o      IF/ID copy of fetch PC + 4
//   opcode_o        instr_o[31:26], consumed directly by the control unit
//   valid_o         IF/ID holds a real (non-bubble) instruction
//   fetch_count_o   number of instructions accepted into IF/ID
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0040_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] imem_addr_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus4_o,
    output logic [5:0]  opcode_o,
    output logic        valid_o,
    output logic [31:0] fetch_count_o
);

    logic [31:0] pc;
    logic [31:0] if_instr;
    logic [31:0] if_pc_plus4;
    logic        if_valid;
    logic [31:0] fetch_count;
    logic [31:0] pc_next_seq;

    // Sequential PC increment; 32-bit modulo, so 0xFFFF_FFFC wraps to 0.
    assign pc_next_seq = pc + 32'd4;

    // A redirect beats a stall because the instruction being held in ID
    // is on the wrong path. A stall ignores imem_data_i entirely, so
    // nothing is skipped or repeated when it releases.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            pc          <= PC_RESET;
            if_instr    <= NOP_WORD;
            if_pc_plus4 <= 32'd0;
            if_valid    <= 1'b0;
            fetch_count <= 32'd0;
        end else if (branch_taken_i) begin
            pc          <= {branch_target_i[31:2], 2'b00};
            if_instr    <= NOP_WORD;
            if_pc_plus4 <= 32'd0;
            if_valid    <= 1'b0;
        end else if (!stall_i) begin
            pc          <= pc_next_seq;
            if_instr    <= imem_data_i;
            if_pc_plus4 <= pc_next_seq;
            if_valid    <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
        end
    end

    assign imem_addr_o   = pc;
    assign instr_o       = if_instr;
    assign pc_plus4_o    = if_pc_plus4;
    assign valid_o       = if_valid;
    assign fetch_count_o = fetch_count;

    // A bubble presents opcode 0 (R-type). The NOP writes $0, so decoding
    // it is harmless.
    assign opcode_o = if_instr[31:26];

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage. The instruction memory is a pure function
// of the address. A behavioural model tracks the architectural view of the
// stage: where fetch is pointing, what sits in IF/ID, and how many words
// have been accepted. A negedge process compares every DUT output against
// that model. Literal expectations at key points of the sequence pin the
// model itself.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        resetN;
    logic        stall;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic [31:0] imemData;
    logic [31:0] imemAddr;
    logic [31:0] instr;
    logic [31:0] pcPlus4;
    logic [5:0]  opcode;
    logic        valid;
    logic [31:0] fetchCount;

    int vecCount  = 0;
    int missCount = 0;

    fetch_stage dut (
        .clk_i           (clk),
        .reset_n_i       (resetN),
        .stall_i         (stall),
        .branch_taken_i  (branchTaken),
        .branch_target_i (branchTarget),
        .imem_data_i     (imemData),
        .imem_addr_o     (imemAddr),
        .instr_o         (instr),
        .pc_plus4_o      (pcPlus4),
        .opcode_o        (opcode),
        .valid_o         (valid),
        .fetch_count_o   (fetchCount)
    );

    // Free-running clock with a 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The instruction memory holds the test program at fixed addresses.
    // Every other address returns a word derived from the address, so a
    // wrong fetch address shows up as a wrong instruction.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        logic [31:0] w;
        case (addr)
            32'h0040_0000: w = 32'h2008_0005;
            32'h0040_0004: w = 32'h3508_00FF;
            32'h0040_0008: w = 32'h2009_0001;
            32'h0040_000C: w = 32'h0000_0020;
            32'h0040_0100: w = 32'h0000_0020;
            32'h0040_0104: w = 32'h3508_00FF;
            32'h0040_0108: w = 32'h2009_0001;
            32'h0040_010C: w = 32'h0000_0000;
            default:       w = {addr[7:0] ^ 8'h5A, 8'hC3, addr[15:0]};
        endcase
        return w;
    endfunction

    assign imemData = memWord(imemAddr);

    // Behavioural model: the fetch pointer, the IF/ID contents and the
    // accepted-word tally, updated from the control inputs sampled at
    // each rising edge.
    bit          modelKnown = 1'b0;
    logic [31:0] mFetchPc;
    logic [31:0] mIdWord;
    logic [31:0] mIdLink;
    logic        mIdReal;
    logic [31:0] mAccepted;

    always @(posedge clk) begin
        if (resetN === 1'b0) begin
            modelKnown = 1'b1;
            mFetchPc   = 32'h0040_0000;
            mIdWord    = 32'h0000_0000;
            mIdLink    = 32'h0000_0000;
            mIdReal    = 1'b0;
            mAccepted  = 32'd0;
        end else if (modelKnown) begin
            if (branchTaken) begin
                mFetchPc = branchTarget & ~32'd3;
                mIdWord  = 32'h0000_0000;
                mIdLink  = 32'h0000_0000;
                mIdReal  = 1'b0;
            end else if (!stall) begin
                mIdWord   = memWord(mFetchPc);
                mFetchPc  = mFetchPc + 32'd4;
                mIdLink   = mFetchPc;
                mIdReal   = 1'b1;
                mAccepted = mAccepted + 32'd1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: actual %h required %h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Every cycle, once the model has been initialised, compare all outputs.
    always @(negedge clk) begin
        if (modelKnown) begin
            checkOutput("model.addr",    imemAddr,            mFetchPc);
            checkOutput("model.instr",   instr,               mIdWord);
            checkOutput("model.opcode",  {26'd0, opcode},     {26'd0, mIdWord[31:26]});
            checkOutput("model.pcplus4", pcPlus4,             mIdLink);
            checkOutput("model.valid",   {31'd0, valid},      {31'd0, mIdReal});
            checkOutput("model.count",   fetchCount,          mAccepted);
        end
    end

    // Drive one cycle of inputs, let the edge happen, and return shortly after.
    task automatic applyStimulus(input logic rn, input logic st, input logic br,
                                 input logic [31:0] tgt);
        resetN       = rn;
        stall        = st;
        branchTaken  = br;
        branchTarget = tgt;
        @(posedge clk);
        #2;
    endtask

    // Compare the full output set against hand-computed values.
    task automatic checkAll(input string tag, input logic [31:0] eAddr,
                            input logic [31:0] eInstr, input logic [31:0] ePp4,
                            input logic eValid, input logic [31:0] eCount);
        checkOutput({tag, ".addr"},    imemAddr,        eAddr);
        checkOutput({tag, ".instr"},   instr,           eInstr);
        checkOutput({tag, ".opcode"},  {26'd0, opcode}, {26'd0, eInstr[31:26]});
        checkOutput({tag, ".pcplus4"}, pcPlus4,         ePp4);
        checkOutput({tag, ".valid"},   {31'd0, valid},  {31'd0, eValid});
        checkOutput({tag, ".count"},   fetchCount,      eCount);
    endtask

    logic [2:0] pattern [12] = '{3'b000, 3'b010, 3'b000, 3'b001, 3'b011,
                                 3'b000, 3'b010, 3'b010, 3'b001, 3'b000,
                                 3'b000, 3'b011};

    initial begin
        resetN       = 1'b0;
        stall        = 1'b0;
        branchTaken  = 1'b0;
        branchTarget = 32'd0;

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkAll("reset", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 32'd0);

        // First real instruction after release.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        checkAll("release", 32'h0040_0004, 32'h2008_0005, 32'h0040_0004, 1'b1, 32'd1);
        checkOutput("release.opcode_lit", {26'd0, opcode}, 32'h08);

        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        checkAll("fetch2", 32'h0040_0008, 32'h3508_00FF, 32'h0040_0008, 1'b1, 32'd2);

        // A two-cycle stall freezes everything.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
            checkAll("stall", 32'h0040_0008, 32'h3508_00FF, 32'h0040_0008, 1'b1, 32'd2);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        checkAll("unstall", 32'h0040_000C, 32'h2009_0001, 32'h0040_000C, 1'b1, 32'd3);

        // Redirect to an unaligned target, which has its low bits dropped.
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0040_0103);
        checkAll("redirect", 32'h0040_0100, 32'h0, 32'h0, 1'b0, 32'd3);

        // Sequential fetch over the redirected block: opcodes 00,0D,08,00.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        checkAll("seq0", 32'h0040_0104, 32'h0000_0020, 32'h0040_0104, 1'b1, 32'd4);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        checkAll("seq1", 32'h0040_0108, 32'h3508_00FF, 32'h0040_0108, 1'b1, 32'd5);
        checkOutput("seq1.opcode_lit", {26'd0, opcode}, 32'h0D);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        checkAll("seq2", 32'h0040_010C, 32'h2009_0001, 32'h0040_010C, 1'b1, 32'd6);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        checkAll("seq3", 32'h0040_0110, 32'h0000_0000, 32'h0040_0110, 1'b1, 32'd7);

        // Redirect and stall together: the redirect wins.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0040_0200);
        checkAll("redirstall", 32'h0040_0200, 32'h0, 32'h0, 1'b0, 32'd7);

        // PC wraparound from the top of the address space.
        applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        checkAll("wraptgt", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 32'd7);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        checkAll("wrap", 32'h0000_0000, 32'hA6C3_FFFC, 32'h0000_0000, 1'b1, 32'd8);

        // Reset during a stall returns every output to its reset value.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
        checkAll("midreset", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 32'd0);

        // Mixed stall/redirect traffic, checked by the model alone.
        for (int i = 0; i < 12; i++)
            applyStimulus(1'b1, pattern[i][1], pattern[i][0],
                          32'h0040_0100 + 32'(i * 4) + 32'd1);
        // Reset during a redirect.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0040_0300);
        checkAll("resetredir", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
